// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and fetch state encodings
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: single-outstanding instruction memory request/response bus
interface fetch_unit_if;
  import riscv_pkg::*;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
  modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry {pc, instr} buffer parking a response ID cannot take yet
module fetch_hold_buf import riscv_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic            full,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out
);
  logic            full_q, full_d;
  logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d;
  always_comb begin
    full_d  = load ? 1'b1 : (full_q && !clear);
    pc_d    = load ? pc_in : pc_q;
    instr_d = load ? instr_in : instr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end
  assign full      = full_q;
  assign pc_out    = pc_q;
  assign instr_out = instr_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues single-outstanding imem requests, fills IF/ID
module fetch_unit import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  fetch_unit_if.master    imem,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);
  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d, if_instr_q, if_instr_d;
  logic            hb_load, hb_clear, hb_full;
  logic [XLEN-1:0] hb_pc, hb_instr;
  logic            load_ok;
  assign load_ok = !if_valid_q || !stall;
  fetch_hold_buf u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hb_load),
    .clear     (hb_clear),
    .pc_in     (req_pc_q),
    .instr_in  (imem.resp_data),
    .full      (hb_full),
    .pc_out    (hb_pc),
    .instr_out (hb_instr)
  );
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    if_valid_d = stall ? if_valid_q : 1'b0;
    if_pc_d    = if_pc_q;
    if_instr_d = stall ? if_instr_q : NOP_INSTR;
    hb_load    = 1'b0;
    hb_clear   = 1'b0;
    if (redirect_valid) begin
      pc_d       = word_align(redirect_pc);
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      // An in-flight request whose response has not come yet must be swallowed later
      if (state_q == S_WAIT) begin
        state_d = imem.resp_valid ? S_REQ : S_WAIT;
        drop_d  = !imem.resp_valid;
      end else if (state_q == S_HOLD) begin
        hb_clear = 1'b1;
        state_d  = S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ: if (imem.req_ready) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end
        S_WAIT: if (imem.resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            pc_d = req_pc_q + XLEN'(4);
            if (load_ok) begin
              if_valid_d = 1'b1;
              if_pc_d    = req_pc_q;
              if_instr_d = imem.resp_data;
              state_d    = S_REQ;
            end else begin
              hb_load = 1'b1;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: if (load_ok && hb_full) begin
          if_valid_d = 1'b1;
          if_pc_d    = hb_pc;
          if_instr_d = hb_instr;
          hb_clear   = 1'b1;
          state_d    = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end
  assign imem.req_valid = (state_q == S_REQ) && !redirect_valid;
  assign imem.req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus async-reset sequence for fetch_unit
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DX  = 32'hDEAD_BEEF;
  typedef struct {
    logic rv; logic [31:0] rpc; logic st, rdy, rsp; logic [31:0] dat;
    logic qv; logic [31:0] qa; logic iv; logic [31:0] ipc, ins;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic stall = 1'b0;
  logic if_valid;
  logic [31:0] if_pc, if_instr;
  int checks = 0;
  int errors = 0;
  vec_t v[$];
  fetch_unit_if imem ();
  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem           (imem.master),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );
  always #5 clk = ~clk;
  task automatic add(input logic rv, input logic [31:0] rpc, input logic st, rdy, rsp,
                     input logic [31:0] dat, input logic qv, input logic [31:0] qa,
                     input logic iv, input logic [31:0] ipc, ins);
    vec_t e;
    e.rv = rv; e.rpc = rpc; e.st = st; e.rdy = rdy; e.rsp = rsp; e.dat = dat;
    e.qv = qv; e.qa = qa; e.iv = iv; e.ipc = ipc; e.ins = ins;
    v.push_back(e);
  endtask
  task automatic chk(input string n, input int i, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", n, i, act, exp);
    end
  endtask
  task automatic chk_all(input int i, input logic qv, input logic [31:0] qa,
                         input logic iv, input logic [31:0] ipc, ins);
    chk("req_valid", i, {31'b0, imem.req_valid}, {31'b0, qv});
    chk("req_addr", i, imem.req_addr, qa);
    chk("if_valid", i, {31'b0, if_valid}, {31'b0, iv});
    chk("if_pc", i, if_pc, ipc);
    chk("if_instr", i, if_instr, ins);
  endtask
  task automatic drive(input logic rv, input logic [31:0] rpc, input logic st, rdy, rsp,
                       input logic [31:0] dat);
    redirect_valid = rv; redirect_pc = rpc; stall = st;
    imem.req_ready = rdy; imem.resp_valid = rsp; imem.resp_data = dat;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    // rv rpc st rdy rsp dat | qv qa iv ipc ins
    add(0, 0, 0, 1, 0, 0,             1, 32'h0,   0, 32'h0, NOP);
    add(0, 0, 0, 0, 1, 32'h1000_0000, 0, 32'h0,   0, 32'h0, NOP);
    add(0, 0, 0, 1, 0, 0,             1, 32'h4,   1, 32'h0, 32'h1000_0000);
    add(0, 0, 0, 0, 1, 32'h1000_0001, 0, 32'h4,   0, 32'h0, NOP);
    add(0, 0, 0, 1, 0, 0,             1, 32'h8,   1, 32'h4, 32'h1000_0001);
    add(0, 0, 0, 0, 1, 32'h1000_0002, 0, 32'h8,   0, 32'h4, NOP);
    add(0, 0, 1, 1, 0, 0,             1, 32'hC,   1, 32'h8, 32'h1000_0002);
    add(0, 0, 1, 0, 1, 32'h1000_0003, 0, 32'hC,   1, 32'h8, 32'h1000_0002);
    add(0, 0, 1, 1, 0, 0,             0, 32'h10,  1, 32'h8, 32'h1000_0002);
    add(0, 0, 0, 1, 0, 0,             0, 32'h10,  1, 32'h8, 32'h1000_0002);
    add(0, 0, 0, 1, 0, 0,             1, 32'h10,  1, 32'hC, 32'h1000_0003);
    add(1, 32'h100, 0, 0, 0, 0,       0, 32'h10,  0, 32'hC, NOP);
    add(0, 0, 0, 1, 1, DX,            0, 32'h100, 0, 32'hC, NOP);
    add(0, 0, 0, 1, 0, 0,             1, 32'h100, 0, 32'hC, NOP);
    add(0, 0, 0, 0, 1, 32'h1000_0004, 0, 32'h100, 0, 32'hC, NOP);
    add(0, 0, 0, 1, 0, 0,             1, 32'h104, 1, 32'h100, 32'h1000_0004);
    add(1, 32'h203, 0, 0, 1, DX,      0, 32'h104, 0, 32'h100, NOP);
    add(0, 0, 0, 1, 0, 0,             1, 32'h200, 0, 32'h100, NOP);
    add(0, 0, 0, 0, 1, 32'h1000_0005, 0, 32'h200, 0, 32'h100, NOP);
    add(1, 32'hFFFF_FFFC, 0, 1, 0, 0, 0, 32'h204, 1, 32'h200, 32'h1000_0005);
    add(0, 0, 0, 1, 0, 0,             1, 32'hFFFF_FFFC, 0, 32'h200, NOP);
    add(0, 0, 0, 0, 1, 32'h1000_0006, 0, 32'hFFFF_FFFC, 0, 32'h200, NOP);
    add(0, 0, 0, 0, 0, 0,             1, 32'h0,   1, 32'hFFFF_FFFC, 32'h1000_0006);
    add(0, 0, 0, 1, 0, 0,             1, 32'h0,   0, 32'hFFFF_FFFC, NOP);
    add(0, 0, 0, 0, 1, 32'h1000_0007, 0, 32'h0,   0, 32'hFFFF_FFFC, NOP);
    add(0, 0, 1, 1, 0, 0,             1, 32'h4,   1, 32'h0, 32'h1000_0007);
    add(0, 0, 1, 0, 1, 32'h1000_0008, 0, 32'h4,   1, 32'h0, 32'h1000_0007);
    add(1, 32'h40, 1, 0, 0, 0,        0, 32'h8,   1, 32'h0, 32'h1000_0007);
    add(0, 0, 0, 1, 0, 0,             1, 32'h40,  0, 32'h0, NOP);
    add(0, 0, 0, 0, 1, 32'h1000_0009, 0, 32'h40,  0, 32'h0, NOP);
    add(0, 0, 0, 1, 0, 0,             1, 32'h44,  1, 32'h40, 32'h1000_0009);
    @(negedge clk);
    #1 chk_all(-1, 1, 32'h0, 0, 32'h0, NOP);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].rv, v[i].rpc, v[i].st, v[i].rdy, v[i].rsp, v[i].dat);
      #1 chk_all(i, v[i].qv, v[i].qa, v[i].iv, v[i].ipc, v[i].ins);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0);
    #1 chk_all(100, 0, 32'h44, 0, 32'h40, NOP);
    rst = 1'b1;
    #1 chk_all(101, 1, 32'h0, 0, 32'h0, NOP);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    #1 chk_all(102, 1, 32'h0, 0, 32'h0, NOP);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 32'h1000_000A);
    #1 chk_all(103, 0, 32'h0, 0, 32'h0, NOP);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1 chk_all(104, 1, 32'h4, 1, 32'h0, 32'h1000_000A);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end of the five-stage core. It consumes the next-PC decision made in execute (a redirect), owns the architectural fetch PC, and issues requests to instruction memory over a single-outstanding valid/ready request and valid response interface. It delivers fetched instructions into the IF/ID register under stall and flush control from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value of if_instr when it holds no valid instruction (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- redirect_valid  input  1  execute stage orders a PC change (taken branch, jal, jalr).
- redirect_pc  input  32  target address from the next-PC logic.
- stall  input  1  ID cannot accept; hold IF/ID contents.
- imem_req_valid  output  1  fetch request present.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_resp_valid  input  1  response data valid; at most one per accepted request, earliest the cycle after acceptance.
- imem_resp_data  input  32  fetched instruction.
- if_valid  output  1  IF/ID holds a live instruction.
- if_pc  output  32  PC of the IF/ID instruction.
- if_instr  output  32  IF/ID instruction.

Behaviour:
- Reset (async, while rst=1): state=S_REQ, pc=RESET_PC, drop=0, hold buffer empty, if_valid=0, if_pc=0, if_instr=NOP_INSTR.
- Alignment: pc[1:0] is always 00. The fetch unit forces redirect_pc[1:0] to 00.
- imem_req_addr = pc (combinational). imem_req_valid = (state==S_REQ) && !redirect_valid.
- IF/ID load condition: load_ok = !if_valid || !stall.
- If !stall and nothing new is loaded, if_valid goes to 0 and if_instr to NOP_INSTR, because ID has consumed the instruction.
- States:
  - S_REQ: on handshake (req_valid && req_ready), latch req_pc=pc and go to S_WAIT.
  - S_WAIT, response arrives with drop=1: discard it, clear drop, go to S_REQ.
  - S_WAIT, response arrives with drop=0 and load_ok: if_valid=1, if_pc=req_pc, if_instr=resp_data, pc=req_pc+4, go to S_REQ.
  - S_WAIT, response arrives with drop=0 and !load_ok: capture {req_pc, data} into the hold buffer, pc=req_pc+4, go to S_HOLD.
  - S_HOLD: when load_ok, move the hold buffer into IF/ID, go to S_REQ. No request is issued while in S_HOLD.
- Redirect has highest priority over stall and over any response:
  - pc<=redirect_pc, if_valid<=0, if_instr<=NOP_INSTR.
  - In S_REQ: no request is issued that cycle; stay in S_REQ.
  - In S_WAIT with no response that cycle: drop<=1, stay in S_WAIT.
  - In S_WAIT with a response the same cycle: discard the response, go to S_REQ, drop stays 0.
  - In S_HOLD: empty the hold buffer, go to S_REQ.
- Throughput: at most one instruction per 2 cycles (single outstanding request).
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Reset mid-transaction: any in-flight response arriving after rst deasserts is treated as a fresh response. Memory is reset on the same rst, so no stale response arrives.

Decomposition:
- Shared riscv_pkg holds: XLEN=32, NOP_INSTR, and the fetch state encodings S_REQ/S_WAIT/S_HOLD (2-bit).
- One sub-module: fetch_hold_buf, a one-entry {pc, instr} buffer with load/clear/full.

Test Plan:
- Reset, then memory ready with 1-cycle response: req addrs 0x0,0x4,0x8. if_pc/if_instr follow each response one cycle later; if_valid pulses with the 2-cycle cadence.
- stall=1 with if_valid=1 when the response for 0x4 arrives: state=S_HOLD, no new request, IF/ID keeps 0x0. Drop stall: IF/ID=0x4, then request 0x8 issues.
- redirect_valid=1, redirect_pc=0x100 while in S_WAIT for 0x8: the 0x8 response is discarded, if_valid=0, the next request addr is 0x100, and the following IF/ID is pc=0x100.
- Redirect in the same cycle as a response: the response is discarded, no drop flag remains, and the next request is the redirect target.
- redirect_pc=0x203 (jalr odd target): the request addr is 0x200.
- pc=0xFFFF_FFFC fetched: the next request addr is 0x0. Assert rst mid-S_WAIT: outputs return to their reset values immediately (asynchronously).
